// File: rtl/dm9000_bus_ctrl.sv
// Request/acknowledge host-bus master for the DM9000A: index and data cycles with
// programmable setup/strobe/hold/gap timing and read-data capture.
module dm9000_bus_ctrl #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned GAP_CYC    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_we,
  input  logic              req_noidx,
  input  logic [7:0]        req_reg,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              irq,
  input  logic              eth_int,
  input  logic [DATA_W-1:0] eth_data_i,
  output logic [DATA_W-1:0] eth_data_o,
  output logic              eth_data_oe,
  output logic              eth_cs_n,
  output logic              eth_cmd,
  output logic              eth_ior_n,
  output logic              eth_iow_n
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MaxCyc = max2(max2(SETUP_CYC, STROBE_CYC), max2(HOLD_CYC, GAP_CYC));
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  typedef logic [CntW-1:0] cnt_t;

  // Counter holds (cycles - 1) so the phase ends when it reaches zero.
  localparam cnt_t LdSetup  = cnt_t'(SETUP_CYC - 1);
  localparam cnt_t LdStrobe = cnt_t'(STROBE_CYC - 1);
  localparam cnt_t LdHold   = cnt_t'(HOLD_CYC - 1);
  localparam cnt_t LdGap    = cnt_t'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

  typedef enum logic [3:0] {
    StIdle,
    StIdxSetup,
    StIdxStrobe,
    StIdxHold,
    StGap,
    StDatSetup,
    StDatStrobe,
    StDatHold,
    StDone
  } state_e;

  state_e            state_q, state_d;
  cnt_t              cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [7:0]        reg_q, reg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              expired;

  logic              cs_n_q, cmd_q, ior_n_q, iow_n_q, oe_q;
  logic              cs_n_d, cmd_d, ior_n_d, iow_n_d, oe_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] idx_word;
  logic              sync1_q, sync2_q;

  assign expired = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = expired ? cnt_q : cnt_q - 1'b1;
    we_d    = we_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          we_d    = req_we;
          reg_d   = req_reg;
          wdata_d = req_wdata;
          state_d = req_noidx ? StDatSetup : StIdxSetup;
          cnt_d   = LdSetup;
        end
      end
      StIdxSetup: if (expired) begin
        state_d = StIdxStrobe;
        cnt_d   = LdStrobe;
      end
      StIdxStrobe: if (expired) begin
        state_d = StIdxHold;
        cnt_d   = LdHold;
      end
      StIdxHold: if (expired) begin
        if (GAP_CYC > 0) begin
          state_d = StGap;
          cnt_d   = LdGap;
        end else begin
          state_d = StDatSetup;
          cnt_d   = LdSetup;
        end
      end
      StGap: if (expired) begin
        state_d = StDatSetup;
        cnt_d   = LdSetup;
      end
      StDatSetup: if (expired) begin
        state_d = StDatStrobe;
        cnt_d   = LdStrobe;
      end
      StDatStrobe: if (expired) begin
        state_d = StDatHold;
        cnt_d   = LdHold;
      end
      StDatHold: if (expired) begin
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pad controls are decoded from the next state and registered, so the bus
  // pins come straight from flops and never glitch between phases.
  always_comb begin
    idx_word      = '0;
    idx_word[7:0] = reg_d;
    cs_n_d  = 1'b1;
    cmd_d   = 1'b1;
    ior_n_d = 1'b1;
    iow_n_d = 1'b1;
    oe_d    = 1'b0;
    dout_d  = '0;
    unique case (state_d)
      StIdxSetup, StIdxHold: begin
        cs_n_d = 1'b0;
        cmd_d  = 1'b0;
        oe_d   = 1'b1;
        dout_d = idx_word;
      end
      StIdxStrobe: begin
        cs_n_d  = 1'b0;
        cmd_d   = 1'b0;
        oe_d    = 1'b1;
        dout_d  = idx_word;
        iow_n_d = 1'b0;
      end
      StGap: cs_n_d = 1'b0;
      StDatSetup, StDatHold: begin
        cs_n_d = 1'b0;
        oe_d   = we_d;
        dout_d = we_d ? wdata_d : '0;
      end
      StDatStrobe: begin
        cs_n_d  = 1'b0;
        oe_d    = we_d;
        dout_d  = we_d ? wdata_d : '0;
        iow_n_d = ~we_d;
        ior_n_d = we_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      reg_q   <= '0;
      wdata_q <= '0;
      cs_n_q  <= 1'b1;
      cmd_q   <= 1'b1;
      ior_n_q <= 1'b1;
      iow_n_q <= 1'b1;
      oe_q    <= 1'b0;
      dout_q  <= '0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      cs_n_q  <= cs_n_d;
      cmd_q   <= cmd_d;
      ior_n_q <= ior_n_d;
      iow_n_q <= iow_n_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      // Last edge of the read strobe: IOR# is still low while data is sampled.
      if (state_q == StDatStrobe && expired && !we_q) begin
        rdata <= eth_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= eth_int;
      sync2_q <= sync1_q;
    end
  end

  assign busy        = (state_q != StIdle);
  assign ack         = (state_q == StDone);
  assign irq         = sync2_q;
  assign eth_cs_n    = cs_n_q;
  assign eth_cmd     = cmd_q;
  assign eth_ior_n   = ior_n_q;
  assign eth_iow_n   = iow_n_q;
  assign eth_data_oe = oe_q;
  assign eth_data_o  = dout_q;

endmodule

// File: tb/tb_dm9000_bus_ctrl.sv
// Bench for dm9000_bus_ctrl: default 16-bit instance plus an 8-bit, GAP=0 instance,
// checked cycle by cycle against a timing-rule model.
module tb_dm9000_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req8, req_we, req_noidx;
  logic [7:0]  req_reg;
  logic [15:0] req_wdata;
  logic        eth_int;

  logic        busy, ack, irq, oe, cs_n, cmd, ior_n, iow_n;
  logic [15:0] rdata, d_in, d_out;
  logic        busy8, ack8, irq8, oe8, cs8_n, cmd8, ior8_n, iow8_n;
  logic [7:0]  rdata8, d8_in, d8_out, rd8_val;

  logic [15:0] rd_mem [64];
  int          rd_ptr = 0;
  bit          ior_low = 1'b0;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  dm9000_bus_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_noidx(req_noidx),
    .req_reg(req_reg), .req_wdata(req_wdata), .busy(busy), .ack(ack), .rdata(rdata),
    .irq(irq), .eth_int(eth_int), .eth_data_i(d_in), .eth_data_o(d_out),
    .eth_data_oe(oe), .eth_cs_n(cs_n), .eth_cmd(cmd), .eth_ior_n(ior_n), .eth_iow_n(iow_n)
  );

  dm9000_bus_ctrl #(
    .DATA_W(8), .SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(1), .GAP_CYC(0)
  ) dut8 (
    .clk(clk), .rst(rst), .req(req8), .req_we(req_we), .req_noidx(req_noidx),
    .req_reg(req_reg), .req_wdata(req_wdata[7:0]), .busy(busy8), .ack(ack8),
    .rdata(rdata8), .irq(irq8), .eth_int(eth_int), .eth_data_i(d8_in),
    .eth_data_o(d8_out), .eth_data_oe(oe8), .eth_cs_n(cs8_n), .eth_cmd(cmd8),
    .eth_ior_n(ior8_n), .eth_iow_n(iow8_n)
  );

  // Device model: read data only valid while IOR# is low; 16-bit side pops a FIFO.
  assign d_in  = ior_n ? 16'hFFFF : rd_mem[rd_ptr[5:0]];
  assign d8_in = ior8_n ? 8'h00 : rd8_val;

  always @(negedge clk) begin
    if (!ior_n) ior_low = 1'b1;
    else if (ior_low) begin
      ior_low = 1'b0;
      rd_ptr  = rd_ptr + 1;
    end
  end

  typedef struct packed {
    logic        cs_n, cmd, ior_n, iow_n, oe, busy, ack;
    logic [15:0] data;
  } out_t;

  typedef struct {
    bit          use8, we, noidx, pulse;
    logic [7:0]  rg;
    logic [15:0] wd, rd;
    int          exp_ack;
  } vec_t;

  task automatic chk(input string nm, input int cyc, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  // Expected pins from the timing rules: phases of P cycles, strobe after setup.
  function automatic out_t model(input int c, input int s, input int t, input int h,
                                 input int g, input bit we, input bit noidx,
                                 input logic [7:0] rg, input logic [15:0] wd);
    int p, ackc, ds;
    bit in_idx, in_gap, in_dat, stb_idx, stb_dat;
    out_t o;
    p       = s + t + h;
    ackc    = noidx ? p + 1 : 2 * p + g + 1;
    ds      = noidx ? 1 : p + g + 1;
    in_idx  = !noidx && c >= 1 && c <= p;
    in_gap  = !noidx && c > p && c <= p + g;
    in_dat  = c >= ds && c < ds + p;
    stb_idx = in_idx && c >= 1 + s && c < 1 + s + t;
    stb_dat = in_dat && c >= ds + s && c < ds + s + t;
    o.cs_n  = !(in_idx || in_gap || in_dat);
    o.cmd   = !in_idx;
    o.ior_n = !(stb_dat && !we);
    o.iow_n = !(stb_idx || (stb_dat && we));
    o.oe    = in_idx || (in_dat && we);
    o.busy  = c >= 1 && c <= ackc;
    o.ack   = (c == ackc);
    o.data  = in_idx ? {8'h00, rg} : ((in_dat && we) ? wd : 16'h0000);
    return o;
  endfunction

  function automatic out_t sample(input bit use8);
    out_t g;
    if (use8) begin
      g.cs_n = cs8_n; g.cmd = cmd8; g.ior_n = ior8_n; g.iow_n = iow8_n;
      g.oe = oe8; g.busy = busy8; g.ack = ack8; g.data = {8'h00, d8_out};
    end else begin
      g.cs_n = cs_n; g.cmd = cmd; g.ior_n = ior_n; g.iow_n = iow_n;
      g.oe = oe; g.busy = busy; g.ack = ack; g.data = d_out;
    end
    return g;
  endfunction

  task automatic do_txn(input vec_t v);
    int s, t, h, g, p, ackc, nacks, ack_at;
    out_t got, exp;
    logic [15:0] exp_rd, rd_before, rd_now;
    s = v.use8 ? 2 : 1; t = v.use8 ? 3 : 2; h = 1; g = v.use8 ? 0 : 1;
    p = s + t + h;
    ackc = v.noidx ? p + 1 : 2 * p + g + 1;
    nacks = 0; ack_at = -1; exp_rd = 16'h0; rd_before = 16'h0;
    for (int c = 0; c <= ackc + 1; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        if (v.use8) begin
          rd8_val = v.rd[7:0];
          exp_rd  = {8'h00, v.rd[7:0]};
          req8    = 1'b1;
        end else begin
          rd_mem[rd_ptr[5:0]] = v.rd;
          exp_rd = v.rd;
          req    = 1'b1;
        end
        req_we = v.we; req_noidx = v.noidx; req_reg = v.rg; req_wdata = v.wd;
      end else begin
        req = 1'b0; req8 = 1'b0;
        req_we = ~v.we; req_noidx = ~v.noidx;
        req_reg = 8'($urandom); req_wdata = 16'($urandom);
        if (v.pulse && (c == 3 || c == 8)) req = 1'b1;
      end
      @(negedge clk);
      rd_now = v.use8 ? {8'h00, rdata8} : rdata;
      if (c == 0) rd_before = rd_now;
      got = sample(v.use8);
      exp = model(c, s, t, h, g, v.we, v.noidx, v.rg, v.wd);
      if (v.use8) exp.data = exp.data & 16'h00FF;
      if (!exp.oe) begin
        exp.data = '0;
        got.data = '0;
      end
      chk("pins", c, 32'(got), 32'(exp));
      if (got.ack) begin
        nacks++;
        ack_at = c;
      end
      if (c == ackc) chk(v.we ? "rdata_kept" : "rdata", c, 32'(rd_now),
                         32'(v.we ? rd_before : exp_rd));
    end
    chk("ack_count", ackc, nacks, 1);
    chk("ack_cycle", ackc, ack_at, v.exp_ack);
  endtask

  vec_t tbl[8];

  initial begin
    int p0, nack, cmd_low;
    int ack_cyc[4];
    logic [15:0] got_rd[4];
    logic [15:0] exp_q[$];
    vec_t rv;
    logic hist[$];
    bit seen_ack;

    //            use8  we    noidx pulse rg      wd         rd         ack
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h1F, 16'h0000, 16'h0000, 10};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h28, 16'h0000, 16'h0A46, 10};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 16'hA5C3, 16'h0000, 5};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 16'h0000, 16'h1234, 5};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 16'h005A, 16'h0000, 13};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h0A, 16'hBEEF, 16'h0000, 10};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hF0, 16'h0000, 16'h00C7, 7};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h44, 16'h0000, 16'h0093, 13};

    for (int i = 0; i < 64; i++) rd_mem[i] = 16'($urandom);
    rst = 1'b1; req = 1'b0; req8 = 1'b0; req_we = 1'b0; req_noidx = 1'b0;
    req_reg = 8'h00; req_wdata = 16'h0000; eth_int = 1'b0; rd8_val = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset16", 0, {busy, ack, irq, cs_n, cmd, ior_n, iow_n, oe, d_out, rdata},
        {3'b000, 4'b1111, 1'b0, 32'h0});
    chk("reset8", 0, {busy8, ack8, irq8, cs8_n, cmd8, ior8_n, iow8_n, oe8, d8_out, rdata8},
        {3'b000, 4'b1111, 1'b0, 16'h0});
    @(posedge clk); #1 rst = 1'b0;

    foreach (tbl[i]) do_txn(tbl[i]);

    // Data-only FIFO burst, req held high so each acceptance is back-to-back.
    @(posedge clk);
    p0 = rd_ptr; nack = 0; cmd_low = 0;
    for (int k = 0; k < 4; k++) exp_q.push_back(rd_mem[6'(p0 + k)]);
    for (int c = 0; c <= 30; c++) begin
      @(posedge clk); #1;
      req = (c <= 18); req_noidx = 1'b1; req_we = 1'b0; req_reg = 8'hF0;
      @(negedge clk);
      if (!cmd) cmd_low++;
      if (ack) begin
        if (nack < 4) begin
          ack_cyc[nack] = c;
          got_rd[nack]  = rdata;
        end
        nack++;
      end
    end
    chk("burst_cmd_low", 0, cmd_low, 0);
    chk("burst_acks", 0, nack, 4);
    for (int k = 0; k < 4 && k < nack; k++) begin
      chk("burst_ack_cyc", k, ack_cyc[k], 5 + 6 * k);
      chk("burst_rdata", k, got_rd[k], exp_q[k]);
    end

    for (int i = 0; i < 40; i++) begin
      rv.use8  = (i % 4 == 3);
      rv.we    = 1'($urandom);
      rv.noidx = 1'($urandom);
      rv.pulse = rv.use8 ? 1'b0 : 1'($urandom);
      rv.rg    = 8'($urandom);
      rv.wd    = 16'($urandom);
      rv.rd    = 16'($urandom);
      if (rv.use8) rv.exp_ack = rv.noidx ? 7 : 13;
      else rv.exp_ack = rv.noidx ? 5 : 10;
      do_txn(rv);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    rv = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 16'h0000, 16'hC3A5, 10};
    do_txn(rv);

    // Reset during the data strobe of a write.
    eth_int = 1'b1;
    @(posedge clk); #1;
    req = 1'b1; req_we = 1'b1; req_noidx = 1'b0; req_reg = 8'h11; req_wdata = 16'h7777;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      req = 1'b0;
      if (c == 7) rst = 1'b1;
    end
    @(negedge clk);
    chk("pre_rst_iow", 7, {iow_n, irq}, 2'b01);
    @(negedge clk);
    chk("mid_rst", 8, {busy, ack, irq, cs_n, cmd, ior_n, iow_n, oe, d_out, rdata},
        {3'b000, 4'b1111, 1'b0, 32'h0});
    @(posedge clk); #1 rst = 1'b0;
    seen_ack = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ack || busy) seen_ack = 1'b1;
    end
    chk("no_ack_after_rst", 0, seen_ack, 0);
    rv = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 16'h5AA5, 16'h0000, 10};
    do_txn(rv);

    // Interrupt synchroniser: irq equals eth_int as seen two edges earlier.
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      hist.push_back(eth_int);
      #3 eth_int = 1'($urandom);
      @(negedge clk);
      if (hist.size() >= 2) chk("irq", k, irq, hist[hist.size() - 2]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/dm9000_bus_ctrl.md
# dm9000_bus_ctrl

Parametrised host-bus master for the DM9000A Ethernet controller, replacing hand-sequenced strobe generation with a request/acknowledge transaction engine. A client issues a single register read or write (index cycle followed by data cycle) or a data-only cycle for FIFO bursts. The block generates CS#/CMD/IOR#/IOW# with programmable setup, strobe, hold and inter-phase gap, and captures read data. It sits between the packet/control logic and the top-level tristate `eth_data` pad, which is driven from `eth_data_o`/`eth_data_oe`.

## Interface
- DATA_W, 16, bus width (8 or 16); in 8-bit mode the index is driven on bits [7:0]
- SETUP_CYC, 1, cycles CMD/data are stable before the strobe falls (≥1)
- STROBE_CYC, 2, cycles IOR#/IOW# are held low (≥1)
- HOLD_CYC, 1, cycles CMD/data are held after the strobe rises (≥1)
- GAP_CYC, 1, idle cycles between the index and data phases (≥0)

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- req  in  1  transaction request; accepted when busy=0
- req_we  in  1  1=write, 0=read
- req_noidx  in  1  1=skip the index phase (data-only cycle)
- req_reg  in  8  register index
- req_wdata  in  DATA_W  write data
- busy  out  1  transaction in progress
- ack  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read data; valid from the ack cycle, held until the next read completes
- irq  out  1  eth_int after a 2-flop synchroniser
- eth_int  in  1  DM9000A interrupt, asynchronous
- eth_data_i  in  DATA_W  pad input
- eth_data_o  out  DATA_W  pad output
- eth_data_oe  out  1  pad output enable
- eth_cs_n, eth_cmd, eth_ior_n, eth_iow_n  out  1 each  DM9000A bus controls

## Operation
- States: IDLE → IDX_SETUP → IDX_STROBE → IDX_HOLD → GAP → DAT_SETUP → DAT_STROBE → DAT_HOLD → DONE → IDLE.
  - req_noidx=1: IDLE → DAT_SETUP.
  - GAP_CYC=0: GAP is skipped.
- A single down-counter is loaded on each state entry. Its width fits the largest parameter.
- Acceptance: in IDLE, req=1 latches req_we, req_noidx, req_reg and req_wdata. Later input changes are ignored. req while busy=1 is dropped, not queued.
- Index phase:
  - eth_cmd=0.
  - eth_data_o={0, req_reg}.
  - eth_data_oe=1.
  - eth_iow_n=0 during IDX_STROBE, for both reads and writes.
- Data phase:
  - eth_cmd=1.
  - Write: eth_data_o=wdata, oe=1, eth_iow_n=0 during DAT_STROBE.
  - Read: oe=0 throughout the phase, eth_ior_n=0 during DAT_STROBE. eth_data_i is captured into rdata on the last edge of DAT_STROBE.
- eth_cs_n=0 from the first SETUP cycle through the last HOLD cycle, including GAP. It is 1 in IDLE and DONE.
- During GAP: strobes high, oe=0, eth_cmd=1.
- DONE: ack=1 for exactly one cycle. busy stays 1 in DONE and drops in the following IDLE cycle.
- IOR# and IOW# are never low simultaneously. oe is never 1 while IOR# is low.
- Reset values, including reset asserted mid-transaction:
  - state=IDLE, busy=0, ack=0, rdata=0, irq=0.
  - eth_cs_n=1, eth_cmd=1, eth_ior_n=1, eth_iow_n=1, eth_data_oe=0, eth_data_o=0.
  - An aborted transaction produces no ack. Strobes return high on the cycle after the reset edge.

## Timing
- Let P = SETUP_CYC+STROBE_CYC+HOLD_CYC. Cycle 0 is the cycle in which req=1 and busy=0.
- busy=1 from cycle 1 through the ack cycle.
- Full transaction: ack in cycle 2P+GAP_CYC+1. Default parameters: cycle 10.
- Data-only transaction: ack in cycle P+1. Default parameters: cycle 5.
- Strobe within a phase starting at cycle s: low in cycles s+SETUP_CYC … s+SETUP_CYC+STROBE_CYC−1.
- Earliest next acceptance: cycle ack+1. Back-to-back issue is 1 idle cycle apart.
- irq follows eth_int with 2-cycle latency. It does not depend on reset, except that it clears to 0 during reset.

## Test plan
- Write, defaults, req_reg=0x1F, wdata=0x0000:
  - CMD=0 in cycles 1–4, IOW# low in cycles 2–3, gap in cycle 5.
  - CMD=1 in cycles 6–9, IOW# low in cycles 7–8.
  - ack in cycle 10. cs_n=0 in cycles 1–9.
- Read, req_reg=0x28, model drives 0x0A46 while IOR# is low:
  - rdata=0x0A46 at ack (cycle 10).
  - oe=0 in cycles 5–10. IOR# low only in cycles 7–8.
- Data-only read of 0xF0 burst, 4 back-to-back requests:
  - no CMD=0 cycles.
  - acks 6 cycles apart.
  - rdata sequence matches the model FIFO.
- Parameters DATA_W=8, SETUP=2, STROBE=3, HOLD=1, GAP=0, full write:
  - ack in cycle 13.
  - index on [7:0].
  - GAP state skipped; data SETUP begins in cycle 7.
- req pulsed in cycles 3 and 8 of a transaction: both ignored, exactly one ack. rst asserted in cycle 7 (IOW# low): all controls reach their reset values the next cycle, no ack, and a new req after rst is released completes normally.
- eth_int toggled asynchronously: irq follows after 2 edges with no glitches.
